rr_mux4_arbiter: RTL and testbench

//  Sequential front end for the 4-to-1 word mux in the datapath: arbitrates four

---
 rtl/rr_mux4_arbiter_if.sv | 28 ++
 rtl/rr_mux4_arbiter.sv | 82 ++++++++
 tb/tb_rr_mux4_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rr_mux4_arbiter_if.sv
// Four valid/ready source channels in, one registered valid/ready word out.
// The slave modport is the arbiter side; the master modport is the environment.
interface rr_mux4_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_count;

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel, xfer_count
    );

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel, xfer_count
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 arbiter into a one-entry output register; load latency 1 cycle.
// Grants only when the register is empty or draining, so a stalled consumer holds every source.
module rr_mux4_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_mux4_arbiter_if.slave     bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_sel_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       win;
    logic [1:0]       idx;
    logic             any_vld;
    logic             can_load;
    logic             load;
    logic             drain;
    logic [WIDTH-1:0] win_dat;

    // Scan from the pointer upward; the first requester found wins.
    always_comb begin
        win     = 2'd0;
        idx     = 2'd0;
        any_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!any_vld && bus.in_valid[idx]) begin
                win     = idx;
                any_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_dat = '0;
        case (win)
            2'd0: win_dat = bus.in_data0;
            2'd1: win_dat = bus.in_data1;
            2'd2: win_dat = bus.in_data2;
            2'd3: win_dat = bus.in_data3;
            default: win_dat = '0;
        endcase
    end

    assign can_load = (state_q == EMPTY) || bus.out_ready;
    assign load     = can_load && any_vld && !reset;
    assign drain    = (state_q == FULL) && bus.out_ready;

    assign bus.in_ready   = load ? (4'b0001 << win) : 4'b0000;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_data   = out_data_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.xfer_count = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_sel_q  <= 2'd0;
            ptr_q      <= 2'd0;
            cnt_q      <= '0;
        end else begin
            if (drain)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (load) begin
                out_data_q <= win_dat;
                out_sel_q  <= win;
                ptr_q      <= win + 2'd1;
                state_q    <= FULL;
            end else if (drain) begin
                state_q    <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter; a second instance with a 4-bit counter
// shares the stimulus so the counter wrap can be observed.
module tb_rr_mux4_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] d0, d1, d2, d3;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    rr_mux4_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus ();
    rr_mux4_arbiter_if #(.WIDTH(32), .CNT_W(4))  bus_n ();

    assign bus.in_valid    = in_valid;
    assign bus.in_data0    = d0;
    assign bus.in_data1    = d1;
    assign bus.in_data2    = d2;
    assign bus.in_data3    = d3;
    assign bus.out_ready   = out_ready;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.in_data0  = d0;
    assign bus_n.in_data1  = d1;
    assign bus_n.in_data2  = d2;
    assign bus_n.in_data3  = d3;
    assign bus_n.out_ready = out_ready;

    rr_mux4_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rr_mux4_arbiter #(.WIDTH(32), .CNT_W(4)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 4'hF;
        d0 = 32'd1; d1 = 32'd2; d2 = 32'd3; d3 = 32'd4;
        out_ready = 1'b0;

        // Reset state, even with every source requesting
        step();
        step();
        check("rst_in_ready",  64'(bus.in_ready),   64'h0);
        check("rst_out_valid", 64'(bus.out_valid),  64'h0);
        check("rst_out_sel",   64'(bus.out_sel),    64'h0);
        check("rst_out_data",  64'(bus.out_data),   64'h0);
        check("rst_xfer",      64'(bus.xfer_count), 64'h0);

        in_valid = 4'h0;
        reset    = 1'b0;
        step();
        check("idle_out_valid", 64'(bus.out_valid), 64'h0);

        // Single source on channel 2
        in_valid  = 4'b0100;
        d2        = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1;
        check("single_in_ready", 64'(bus.in_ready), 64'h4);
        step();
        in_valid = 4'h0;
        #1;
        check("single_out_valid", 64'(bus.out_valid),  64'h1);
        check("single_out_data",  64'(bus.out_data),   64'hDEADBEEF);
        check("single_out_sel",   64'(bus.out_sel),    64'h2);
        check("single_xfer0",     64'(bus.xfer_count), 64'h0);
        step();
        check("single_drained",   64'(bus.out_valid),  64'h0);
        check("single_xfer1",     64'(bus.xfer_count), 64'h1);
        check("single_keep_data", 64'(bus.out_data),   64'hDEADBEEF);

        // Pointer now 3: with channels 0 and 3 requesting, 3 wins
        d2       = 32'd3;
        in_valid = 4'b1001;
        #1;
        check("ptr3_in_ready", 64'(bus.in_ready), 64'h8);
        step();
        check("ptr3_out_sel",  64'(bus.out_sel),  64'h3);
        check("ptr3_out_data", 64'(bus.out_data), 64'h4);

        // Fairness: all four requesting, one word per cycle, pointer back at 0
        in_valid = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("fair_in_ready_%0d", k), 64'(bus.in_ready), 64'(4'b0001 << ((k - 1) % 4)));
            step();
            check($sformatf("fair_sel_%0d", k),  64'(bus.out_sel),    64'((k - 1) % 4));
            check($sformatf("fair_data_%0d", k), 64'(bus.out_data),   64'((k - 1) % 4 + 1));
            check($sformatf("fair_xfer_%0d", k), 64'(bus.xfer_count), 64'(1 + k));
            check($sformatf("fair_vld_%0d", k),  64'(bus.out_valid),  64'h1);
        end

        // Backpressure: load 0x12345678 from channel 1, then stall 5 cycles
        d1 = 32'h12345678;
        step();
        check("bp_load_sel",  64'(bus.out_sel),  64'h1);
        check("bp_load_data", 64'(bus.out_data), 64'h12345678);
        check("bp_load_xfer", 64'(bus.xfer_count), 64'h7);
        out_ready = 1'b0;
        d0 = 32'hBAD00000; d1 = 32'hBAD00001; d2 = 32'hBAD00002; d3 = 32'hBAD00003;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready), 64'h0);
            step();
            check($sformatf("bp_data_%0d", k), 64'(bus.out_data),   64'h12345678);
            check($sformatf("bp_sel_%0d", k),  64'(bus.out_sel),    64'h1);
            check($sformatf("bp_xfer_%0d", k), 64'(bus.xfer_count), 64'h7);
            check($sformatf("bp_vld_%0d", k),  64'(bus.out_valid),  64'h1);
        end

        // Reset between edges while FULL with out_sel=1
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid),  64'h0);
        check("mid_rst_in_ready",  64'(bus.in_ready),   64'h0);
        check("mid_rst_out_sel",   64'(bus.out_sel),    64'h0);
        check("mid_rst_xfer",      64'(bus.xfer_count), 64'h0);
        step();
        reset     = 1'b0;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        d0 = 32'd1; d1 = 32'd2; d2 = 32'd3; d3 = 32'd4;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'h2);
        step();
        check("post_rst_sel",  64'(bus.out_sel),    64'h1);
        check("post_rst_data", 64'(bus.out_data),   64'h2);
        check("post_rst_xfer", 64'(bus.xfer_count), 64'h0);

        // Counter wrap: 17 completed transfers
        in_valid = 4'hF;
        for (int k = 0; k < 17; k++)
            step();
        check("wrap_wide_xfer",   64'(bus.xfer_count),   64'd17);
        check("wrap_narrow_xfer", 64'(bus_n.xfer_count), 64'd1);

        // Drain: no more requests, register empties and the count steps once more
        in_valid = 4'h0;
        step();
        check("drain_out_valid",  64'(bus.out_valid),    64'h0);
        check("drain_wide_xfer",  64'(bus.xfer_count),   64'd18);
        check("drain_narrow_xfer", 64'(bus_n.xfer_count), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
